adder_result_fifo: RTL and testbench
====================================

ADDER_RESULT_FIFO -- requirements
Module: adder_result_fifo

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the width of the sum word carried per entry.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of entries and SHALL be a power of two, minimum 2.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-005 In_Valid  input  1  SHALL mark Sum/Overflow as valid (driven from the adder's En).
REQ-006 Sum  input  DATA_W ([0:DATA_W-1], bit 0 MSB)  SHALL be the adder sum word.
REQ-007 Overflow  input  1  SHALL be the adder overflow flag paired with Sum.
REQ-008 In_Ready  output  1  SHALL be high when an entry can be accepted.
REQ-009 Out_Valid  output  1  SHALL be high when the head entry is presented.
REQ-010 Out_Ready  input  1  SHALL be the downstream consumer's acceptance.
REQ-011 Out_Data  output  DATA_W ([0:DATA_W-1])  SHALL be the head sum word.
REQ-012 Out_Ovf  output  1  SHALL be the overflow flag of the head entry.
REQ-013 Count  output  clog2(DEPTH)+1  SHALL be the current occupancy, 0..DEPTH.

Function
REQ-014 Push SHALL occur on a cycle with In_Valid=1 and In_Ready=1; it SHALL store {Sum, Overflow} at the write pointer.
REQ-015 Pop SHALL occur on a cycle with Out_Valid=1 and Out_Ready=1; it SHALL advance the read pointer.
REQ-016 In_Ready SHALL equal (Count != DEPTH), registered-state derived with no combinational path from Out_Ready.
REQ-017 Out_Valid SHALL equal (Count != 0); Out_Data/Out_Ovf SHALL show the head entry combinationally (first-word fall-through).
REQ-018 A pushed entry SHALL appear on Out_Data one cycle after the push edge when the FIFO was empty (latency 1, no bypass).
REQ-019 Push and pop in the same cycle SHALL leave Count unchanged and update both pointers.
REQ-020 With the FIFO full, In_Valid SHALL be ignored even if a pop occurs that cycle; no data SHALL be lost or overwritten.
REQ-021 With the FIFO empty, Out_Ready SHALL be ignored; Count SHALL never underflow.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-023 Out_Data/Out_Ovf SHALL hold stable while Out_Valid=1 and Out_Ready=0.

Reset
REQ-024 With Rst_n=0 at a Clk edge, pointers and Count SHALL clear to 0; In_Ready=1, Out_Valid=0 in the following cycle.
REQ-025 Reset mid-operation SHALL discard all stored entries; a push coincident with Rst_n=0 SHALL be dropped.
REQ-026 Storage array SHALL NOT be reset; Out_Data/Out_Ovf are don't-care while Out_Valid=0.

Configuration
REQ-027 Macro ADDER_FIFO_OVF_CNT_EN defined SHALL add output Ovf_Cnt (8 bits), incremented on each push with Overflow=1, saturating at 255, cleared by reset.
REQ-028 Macro ADDER_FIFO_OVF_CNT_EN undefined SHALL omit the Ovf_Cnt port and its logic entirely; all other behaviour unchanged.

Structure
REQ-029 Package adder_pkg SHALL hold DATA_W default (4), DEPTH default (4), OVF_CNT_W (8), and the entry typedef {sum, ovf}.
REQ-030 Storage SHALL be one sub-module, adder_fifo_mem: DEPTH x (DATA_W+1) array, synchronous write, asynchronous read.

Verification
REQ-031 Reset then idle -> Count=0, In_Ready=1, Out_Valid=0 (Ovf_Cnt=0 if enabled).
REQ-032 Push Sum=4'b0010 Ovf=1 with Out_Ready=0 -> next cycle Out_Valid=1, Out_Data=4'b0010, Out_Ovf=1, Count=1.
REQ-033 Push 1,2,3,4 back-to-back, Out_Ready=0 -> Count=4, In_Ready=0; 5th push of 5 ignored; drain yields 1,2,3,4 in order.
REQ-034 Full FIFO, In_Valid=1 and Out_Ready=1 same cycle -> pop only, Count=3, next cycle In_Ready=1.
REQ-035 Count=2, push and pop each cycle for 6 cycles -> Count stays 2, pointers wrap, output order matches input order.
REQ-036 Count=3, Rst_n=0 for one cycle with In_Valid=1 -> Count=0, Out_Valid=0; with macro, 300 Overflow=1 pushes/pops -> Ovf_Cnt=255.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared defaults and entry layout for the adder result FIFO.
package adder_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 4;
  localparam int OVF_CNT_W  = 8;

  typedef struct packed {
    logic [0:DATA_W_DEF-1] sum;
    logic                  ovf;
  } adder_entry_t;
endpackage

// File: rtl/adder_fifo_mem.sv
// Entry storage: synchronous write, asynchronous read, no reset on the array.
module adder_fifo_mem #(
  parameter int W     = 5,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge Clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/adder_result_fifo.sv
// First-word fall-through FIFO buffering {Sum, Overflow} from the adder.
// Optional ADDER_FIFO_OVF_CNT_EN adds a saturating count of overflowed pushes.
module adder_result_fifo
  import adder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH),
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_Valid,
  input  logic [0:DATA_W-1] Sum,
  input  logic              Overflow,
  output logic              In_Ready,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [0:DATA_W-1] Out_Data,
  output logic              Out_Ovf,
  output logic [CW-1:0]     Count
`ifdef ADDER_FIFO_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] Ovf_Cnt
`endif
);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [DATA_W:0] rd_entry;

  // Flags come only from registered occupancy, so no Out_Ready -> In_Ready path.
  assign In_Ready  = (count_q != CW'(DEPTH));
  assign Out_Valid = (count_q != '0);
  assign push      = In_Valid & In_Ready;
  assign pop       = Out_Valid & Out_Ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  adder_fifo_mem #(.W(DATA_W + 1), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .Clk       (Clk),
    .wr_en_i   (push & Rst_n),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i ({Sum, Overflow}),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_entry)
  );

  assign Out_Data = rd_entry[DATA_W:1];
  assign Out_Ovf  = rd_entry[0];
  assign Count    = count_q;

`ifdef ADDER_FIFO_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_cnt_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) ovf_cnt_q <= '0;
    else if (push && Overflow && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
  end

  assign Ovf_Cnt = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_adder_result_fifo.sv
// Scoreboard bench for adder_result_fifo: directed scenarios plus random traffic.
module tb_adder_result_fifo;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              In_Valid = 1'b0;
  logic [0:DATA_W-1] Sum = '0;
  logic              Overflow = 1'b0;
  logic              In_Ready;
  logic              Out_Valid;
  logic              Out_Ready = 1'b0;
  logic [0:DATA_W-1] Out_Data;
  logic              Out_Ovf;
  logic [CW-1:0]     Count;
`ifdef ADDER_FIFO_OVF_CNT_EN
  logic [7:0]        Ovf_Cnt;
`endif

  adder_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Valid  (In_Valid),
    .Sum       (Sum),
    .Overflow  (Overflow),
    .In_Ready  (In_Ready),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (Out_Data),
    .Out_Ovf   (Out_Ovf),
    .Count     (Count)
`ifdef ADDER_FIFO_OVF_CNT_EN
    ,
    .Ovf_Cnt   (Ovf_Cnt)
`endif
  );

  always #5 Clk = ~Clk;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  // Reference: a queue of accepted {sum, ovf} entries plus an occupancy count.
  logic [DATA_W:0] exp_q[$];
  int mcount = 0;
  int movf   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
  endtask

  always @(posedge Clk) begin
    if (!Rst_n) begin
      exp_q.delete();
      mcount = 0;
      movf   = 0;
    end else begin
      bit p, q;
      p = In_Valid && (mcount < DEPTH);
      q = Out_Ready && (mcount > 0);
      if (p) begin
        exp_q.push_back({Sum, Overflow});
        if (Overflow && movf < 255) movf++;
      end
      mcount = mcount + int'(p) - int'(q);
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("count", 32'(Count), 32'(mcount));
      chk("in_ready", 32'(In_Ready), 32'(mcount != DEPTH));
      chk("out_valid", 32'(Out_Valid), 32'(mcount != 0));
`ifdef ADDER_FIFO_OVF_CNT_EN
      chk("ovf_cnt", 32'(Ovf_Cnt), 32'(movf));
`endif
      if (Out_Valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL head_unexpected actual=valid expected=empty t=%0t", $time);
        end else begin
          logic [DATA_W:0] e;
          e = exp_q[0];
          chk("head_data", 32'(Out_Data), 32'(e[DATA_W:1]));
          chk("head_ovf", 32'(Out_Ovf), 32'(e[0]));
          if (Out_Ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit rst_n, input bit iv, input logic [DATA_W-1:0] s,
                     input bit o, input bit rdy);
    Rst_n = rst_n; In_Valid = iv; Sum = s; Overflow = o; Out_Ready = rdy;
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cyc(1, 0, '0, 0, 1);
  endtask

  initial begin
    cyc(0, 0, '0, 0, 0);
    chk_en = 1'b1;
    cyc(0, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);

    // Single push with consumer stalled, held for a few cycles.
    cyc(1, 1, 4'b0010, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, '0, 0, 0);
    drain();

    // Fill to full, extra push must be dropped, then drain in order.
    for (int i = 1; i <= 4; i++) cyc(1, 1, DATA_W'(i), 0, 0);
    cyc(1, 1, 4'd5, 1, 0);
    cyc(1, 0, '0, 0, 0);
    drain();

    // Full with simultaneous push attempt and pop: pop only.
    for (int i = 0; i < 4; i++) cyc(1, 1, DATA_W'(8 + i), i[0], 0);
    cyc(1, 1, 4'hF, 1, 1);
    cyc(1, 0, '0, 0, 0);
    drain();

    // Steady push+pop at occupancy 2 wraps both pointers.
    cyc(1, 1, 4'h3, 0, 0);
    cyc(1, 1, 4'h6, 1, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, DATA_W'(10 + i), i[0], 1);
    drain();

    // Reset with three entries stored and a coincident push.
    for (int i = 0; i < 3; i++) cyc(1, 1, DATA_W'(i + 1), 1, 0);
    cyc(0, 1, 4'h7, 1, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 1);

`ifdef ADDER_FIFO_OVF_CNT_EN
    for (int i = 0; i < 300; i++) cyc(1, 1, DATA_W'(i), 1, 1);
    drain();
`endif

    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
          DATA_W'($urandom), $urandom_range(0, 1), $urandom_range(0, 2) != 0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
